// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and constants for the unified-memory arbiter.
//   state_e    - arbiter FSM states (IDLE, BUSY_I, BUSY_D)
//   grant_e    - grant encoding, also the bit index into the request vector
//   ADDR_W_DEF / DATA_W_DEF - default bus widths
//   CNT_W      - width of the access down-counter (LATENCY up to 15)
package mem_arb_pkg;

    localparam int unsigned ADDR_W_DEF = 16;
    localparam int unsigned DATA_W_DEF = 16;
    localparam int unsigned CNT_W      = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2
    } state_e;

    // Value doubles as the bit position in the eligible-request vector.
    typedef enum logic {
        GNT_I = 1'b0,
        GNT_D = 1'b1
    } grant_e;

endpackage

// File: rtl/mem_arb_if.sv
// mem_arb_if: bundles the IF port, data port and memory-side signals of the arbiter.
//   slave  modport - arbiter side (requests/mem_rdata in; data, done, stall, mem_* out)
//   master modport - requester/memory-model side (mirror of slave)
interface mem_arb_if
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF
);

    // Instruction-fetch port
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic [DATA_W-1:0] if_rdata;
    logic              if_done;
    logic              if_stall;

    // Data (MEM-stage) port
    logic              d_req;
    logic              d_wr;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic [DATA_W-1:0] d_rdata;
    logic              d_done;
    logic              d_stall;

    // Memory side
    logic              mem_en;
    logic              mem_wr;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  if_req, if_addr,
        output if_rdata, if_done, if_stall,
        input  d_req, d_wr, d_addr, d_wdata,
        output d_rdata, d_done, d_stall,
        output mem_en, mem_wr, mem_addr, mem_wdata,
        input  mem_rdata
    );

    modport master (
        output if_req, if_addr,
        input  if_rdata, if_done, if_stall,
        output d_req, d_wr, d_addr, d_wdata,
        input  d_rdata, d_done, d_stall,
        input  mem_en, mem_wr, mem_addr, mem_wdata,
        output mem_rdata
    );

endinterface

// File: rtl/mem_arb_grant.sv
// mem_arb_grant: picks one port from the eligible request vector.
// Optional feature macro: MEM_ARB_FAIR_EN (round-robin when both ports are eligible;
// otherwise the data port always wins).
//   req   in  [1:0] eligible requests, indexed by grant_e
//   last  in  grant_e previous grant (only with MEM_ARB_FAIR_EN)
//   valid out at least one request is eligible
//   gnt   out selected port (meaningful when valid)
module mem_arb_grant
    import mem_arb_pkg::*;
(
    input  logic [1:0] req,
`ifdef MEM_ARB_FAIR_EN
    input  grant_e     last,
`endif
    output logic       valid,
    output grant_e     gnt
);

    always_comb begin
        valid = |req;
        gnt   = GNT_D;
        if (req == 2'b01) begin
            gnt = GNT_I;
        end
`ifdef MEM_ARB_FAIR_EN
        else if (req == 2'b11) begin
            gnt = (last == GNT_D) ? GNT_I : GNT_D;
        end
`endif
    end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares a single-port, fixed-latency memory between the IF and data ports.
// Each granted access holds the memory for LATENCY cycles, then pulses that port's done
// for one cycle with registered read data. Stalls are combinational: req & ~done.
// Optional feature macro: MEM_ARB_FAIR_EN (round-robin grant with a last-grant flop).
//   clk    in   system clock, rising edge
//   rst_n  in   asynchronous active-low reset; aborts any access in flight
//   bus    slave modport of mem_arb_if (IF port, data port, memory side)
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned LATENCY = 4,
    parameter int unsigned ADDR_W  = ADDR_W_DEF,
    parameter int unsigned DATA_W  = DATA_W_DEF
) (
    input logic      clk,
    input logic      rst_n,
    mem_arb_if.slave bus
);

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              wr_q, wr_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
    logic              if_done_q, if_done_d;
    logic              d_done_q, d_done_d;
`ifdef MEM_ARB_FAIR_EN
    grant_e            last_q, last_d;
`endif

    logic [1:0] req_elig;
    logic       gnt_valid;
    grant_e     gnt;

    // A port in its done cycle still shows the finished request on req; mask it.
    assign req_elig = {bus.d_req & ~d_done_q, bus.if_req & ~if_done_q};

    mem_arb_grant u_grant (
        .req   (req_elig),
`ifdef MEM_ARB_FAIR_EN
        .last  (last_q),
`endif
        .valid (gnt_valid),
        .gnt   (gnt)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        wr_d       = wr_q;
        if_rdata_d = if_rdata_q;
        d_rdata_d  = d_rdata_q;
        if_done_d  = 1'b0;
        d_done_d   = 1'b0;
`ifdef MEM_ARB_FAIR_EN
        last_d     = last_q;
`endif
        case (state_q)
            IDLE: begin
                if (gnt_valid) begin
                    cnt_d = CNT_LOAD;
`ifdef MEM_ARB_FAIR_EN
                    last_d = gnt;
`endif
                    if (gnt == GNT_D) begin
                        state_d = BUSY_D;
                        addr_d  = bus.d_addr;
                        wdata_d = bus.d_wdata;
                        wr_d    = bus.d_wr;
                    end else begin
                        state_d = BUSY_I;
                        addr_d  = bus.if_addr;
                        wr_d    = 1'b0;
                    end
                end
            end
            BUSY_I, BUSY_D: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    state_d = IDLE;
                    if (state_q == BUSY_I) begin
                        if_done_d  = 1'b1;
                        if_rdata_d = bus.mem_rdata;
                    end else begin
                        d_done_d = 1'b1;
                        if (!wr_q) begin
                            d_rdata_d = bus.mem_rdata;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            wr_q       <= 1'b0;
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
            if_done_q  <= 1'b0;
            d_done_q   <= 1'b0;
`ifdef MEM_ARB_FAIR_EN
            last_q     <= GNT_I;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            wr_q       <= wr_d;
            if_rdata_q <= if_rdata_d;
            d_rdata_q  <= d_rdata_d;
            if_done_q  <= if_done_d;
            d_done_q   <= d_done_d;
`ifdef MEM_ARB_FAIR_EN
            last_q     <= last_d;
`endif
        end
    end

    // Decoded from state so an asynchronous reset drops the enables immediately.
    assign bus.mem_en    = (state_q != IDLE);
    assign bus.mem_wr    = (state_q == BUSY_D) & wr_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;

    assign bus.if_rdata  = if_rdata_q;
    assign bus.if_done   = if_done_q;
    assign bus.if_stall  = bus.if_req & ~if_done_q;
    assign bus.d_rdata   = d_rdata_q;
    assign bus.d_done    = d_done_q;
    assign bus.d_stall   = bus.d_req & ~d_done_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed, self-checking bench for mem_arbiter (LATENCY = 4).
// Builds with or without MEM_ARB_FAIR_EN; only the fairness vector differs.
module tb_mem_arbiter;
    import mem_arb_pkg::*;

    localparam int unsigned LAT = 4;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    mem_arb_if #(.ADDR_W(16), .DATA_W(16)) bus ();

    mem_arbiter #(.LATENCY(LAT), .ADDR_W(16), .DATA_W(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic clear_inputs();
        bus.if_req    = 1'b0;
        bus.if_addr   = '0;
        bus.d_req     = 1'b0;
        bus.d_wr      = 1'b0;
        bus.d_addr    = '0;
        bus.d_wdata   = '0;
        bus.mem_rdata = '0;
    endtask

    // Called in cycle 0 of an access (the cycle the grant is decided). Walks cycles
    // 1..LAT+1: memory busy with latched address, then the done cycle. mem_rdata is
    // only meaningful in the last access cycle. The active port's address/data are
    // disturbed mid-access and restored before done, so the latched copy must be used.
    task automatic expect_access(input string tag, input bit is_d, input logic [15:0] addr,
                                 input bit wr, input logic [15:0] wdata,
                                 input logic [15:0] rdata, input logic [15:0] exp_rdata,
                                 input bit drop_other);
        logic done_v, stall_v;
        logic [15:0] rdata_v;
        for (int c = 1; c <= int'(LAT) + 1; c++) begin
            @(posedge clk);
            #1;
            bus.mem_rdata = (c == int'(LAT)) ? rdata : 16'hDEAD;
            if (c == 1 && drop_other) begin
                if (is_d) bus.if_req = 1'b0;
                else      bus.d_req  = 1'b0;
            end
            if (c == 2 || c == int'(LAT)) begin
                if (is_d) begin
                    bus.d_addr  = bus.d_addr ^ 16'h0F0F;
                    bus.d_wdata = bus.d_wdata ^ 16'hFFFF;
                end else begin
                    bus.if_addr = bus.if_addr ^ 16'h0F0F;
                end
            end
            #1;
            done_v  = is_d ? bus.d_done : bus.if_done;
            stall_v = is_d ? bus.d_stall : bus.if_stall;
            rdata_v = is_d ? bus.d_rdata : bus.if_rdata;
            if (c <= int'(LAT)) begin
                check_val($sformatf("%s_en_c%0d", tag, c), bus.mem_en, 1);
                check_val($sformatf("%s_addr_c%0d", tag, c), bus.mem_addr, addr);
                check_val($sformatf("%s_wr_c%0d", tag, c), bus.mem_wr, is_d & wr);
                if (is_d && wr) check_val($sformatf("%s_wdata_c%0d", tag, c), bus.mem_wdata, wdata);
                check_val($sformatf("%s_done_c%0d", tag, c), done_v, 0);
                check_val($sformatf("%s_stall_c%0d", tag, c), stall_v, 1);
            end else begin
                check_val($sformatf("%s_en_done", tag), bus.mem_en, 0);
                check_val($sformatf("%s_wr_done", tag), bus.mem_wr, 0);
                check_val($sformatf("%s_done", tag), done_v, 1);
                check_val($sformatf("%s_stall_done", tag), stall_v, 0);
                check_val($sformatf("%s_rdata", tag), rdata_v, exp_rdata);
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected end of test");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit          got_d;
        int          n_gnt;
        logic        prev_en;
        logic [15:0] exp_addr;

        // ---------------- reset with random inputs ----------------
        rst_n = 1'b0;
        clear_inputs();
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            bus.if_req    = 1'($urandom);
            bus.if_addr   = 16'($urandom);
            bus.d_req     = 1'($urandom);
            bus.d_wr      = 1'($urandom);
            bus.d_addr    = 16'($urandom);
            bus.d_wdata   = 16'($urandom);
            bus.mem_rdata = 16'($urandom);
            #1;
            check_val("rst_mem_en", bus.mem_en, 0);
            check_val("rst_mem_wr", bus.mem_wr, 0);
            check_val("rst_mem_addr", bus.mem_addr, 0);
            check_val("rst_mem_wdata", bus.mem_wdata, 0);
            check_val("rst_if_done", bus.if_done, 0);
            check_val("rst_if_rdata", bus.if_rdata, 0);
            check_val("rst_d_done", bus.d_done, 0);
            check_val("rst_d_rdata", bus.d_rdata, 0);
            check_val("rst_if_stall", bus.if_stall, bus.if_req === 1'b1);
            check_val("rst_d_stall", bus.d_stall, bus.d_req === 1'b1);
        end
        @(posedge clk);
        #1;
        clear_inputs();
        rst_n = 1'b1;

        // ---------------- single IF read ----------------
        @(posedge clk);
        #1;
        bus.if_req  = 1'b1;
        bus.if_addr = 16'h0010;
        #1;
        check_val("if1_stall_c0", bus.if_stall, 1);
        check_val("if1_en_c0", bus.mem_en, 0);
        expect_access("if1", 1'b0, 16'h0010, 1'b0, 16'h0, 16'hA5A5, 16'hA5A5, 1'b0);
        // Request dropped only now: the done cycle must not have re-granted it.
        @(posedge clk);
        #1;
        bus.if_req = 1'b0;
        #1;
        check_val("if1_no_regrant", bus.mem_en, 0);
        check_val("if1_done_pulse", bus.if_done, 0);
        check_val("if1_rdata_hold", bus.if_rdata, 16'hA5A5);

        // ---------------- simultaneous IF + data read ----------------
        // Last grant was IF, so both builds pick data first.
        @(posedge clk);
        #1;
        bus.if_req  = 1'b1;
        bus.if_addr = 16'h0100;
        bus.d_req   = 1'b1;
        bus.d_wr    = 1'b0;
        bus.d_addr  = 16'h0200;
        #1;
        check_val("sim_if_stall_c0", bus.if_stall, 1);
        check_val("sim_d_stall_c0", bus.d_stall, 1);
        expect_access("sim_d", 1'b1, 16'h0200, 1'b0, 16'h0, 16'h2222, 16'h2222, 1'b0);
        check_val("sim_if_wait_stall", bus.if_stall, 1);
        check_val("sim_if_wait_done", bus.if_done, 0);
        expect_access("sim_i", 1'b0, 16'h0100, 1'b0, 16'h0, 16'h1111, 16'h1111, 1'b1);
        check_val("sim_d_rdata_hold", bus.d_rdata, 16'h2222);
        @(posedge clk);
        #1;
        bus.if_req = 1'b0;
        #1;
        check_val("sim_idle", bus.mem_en, 0);

        // ---------------- data write ----------------
        @(posedge clk);
        #1;
        bus.d_req   = 1'b1;
        bus.d_wr    = 1'b1;
        bus.d_addr  = 16'h0300;
        bus.d_wdata = 16'h1234;
        #1;
        check_val("wr_stall_c0", bus.d_stall, 1);
        // Memory returns junk on the last cycle; d_rdata must keep the earlier read value.
        expect_access("wr", 1'b1, 16'h0300, 1'b1, 16'h1234, 16'h7777, 16'h2222, 1'b0);
        @(posedge clk);
        #1;
        bus.d_req = 1'b0;
        bus.d_wr  = 1'b0;
        #1;
        check_val("wr_idle", bus.mem_en, 0);

        // ---------------- fairness: both fresh after a data grant ----------------
        @(posedge clk);
        #1;
        bus.if_req  = 1'b1;
        bus.if_addr = 16'h0500;
        bus.d_req   = 1'b1;
        bus.d_addr  = 16'h0600;
        @(posedge clk);
        #2;
`ifdef MEM_ARB_FAIR_EN
        exp_addr = 16'h0500;
`else
        exp_addr = 16'h0600;
`endif
        check_val("fair_first_grant", bus.mem_addr, exp_addr);
        check_val("fair_en", bus.mem_en, 1);

        // ---------------- both held continuously for 40 cycles ----------------
        // The done-cycle mask hands the memory to the other port, so grants alternate
        // D,I,D,I in both builds when starting from reset.
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        n_gnt   = 0;
        prev_en = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk);
            #2;
            if (bus.mem_en && !prev_en) begin
                got_d = (bus.mem_addr == 16'h0600);
                check_val($sformatf("cont_grant%0d", n_gnt), got_d, (n_gnt % 2) == 0);
                n_gnt++;
            end
            prev_en = bus.mem_en;
        end
        check_val("cont_grant_count", n_gnt, 8);

        // ---------------- reset in the 2nd BUSY cycle ----------------
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        clear_inputs();
        bus.d_req  = 1'b1;
        bus.d_addr = 16'h0700;
        rst_n      = 1'b1;
        @(posedge clk);
        #2;
        check_val("abort_en_c1", bus.mem_en, 1);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check_val("abort_en_async", bus.mem_en, 0);
        check_val("abort_addr_async", bus.mem_addr, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        check_val("abort_no_done", bus.d_done, 0);
        check_val("abort_restart_stall", bus.d_stall, 1);
        expect_access("restart", 1'b1, 16'h0700, 1'b0, 16'h0, 16'h4444, 16'h4444, 1'b0);
        @(posedge clk);
        #1;
        bus.d_req = 1'b0;
        #1;
        check_val("restart_idle", bus.mem_en, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
